// File: rtl/clic_arb_pkg.sv
// Shared types and helpers for the CLIC per-hart target arbiter.
//   arb_state_e  : delivery FSM states (IDLE, REQ, KILL)
//   cand_t       : registered candidate {valid, id, level, shv}
//   masked_level : intctl with the non-level low bits forced to 1
package clic_arb_pkg;

  // Wide enough for the largest CLIC (4096 sources); the top zero-extends its ID into it.
  localparam int CAND_ID_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [CAND_ID_W-1:0] id;
    logic [7:0]           level;
    logic                 shv;
  } cand_t;

  // Bits below the nlbits level field read as 1; nlbits above 8 saturates at 8.
  function automatic logic [7:0] masked_level(input logic [7:0] intctl,
                                              input logic [3:0] nlbits);
    logic [3:0] nl;
    nl = (nlbits > 4'd8) ? 4'd8 : nlbits;
    return intctl | (8'hFF >> nl);
  endfunction

endpackage

// File: rtl/clic_max_tree.sv
// Combinational comparator tree selecting the highest-priority eligible source.
// Priority key is {masked level, intctl}; equal keys resolve toward the higher ID.
//   i_elig   : per-source eligible (pending & enabled)
//   i_shv    : per-source selective hardware vectoring bit
//   i_intctl : per-source intctl (unimplemented bits already forced to 1)
//   i_nlbits : level-bit count from mcliccfg
//   o_valid/o_id/o_level/o_shv : winner of the tree
module clic_max_tree
  import clic_arb_pkg::*;
#(
  parameter int N_SOURCE = 32,
  parameter int SRC_W    = $clog2(N_SOURCE)
) (
  input  logic [N_SOURCE-1:0] i_elig,
  input  logic [N_SOURCE-1:0] i_shv,
  input  logic [7:0]          i_intctl [N_SOURCE],
  input  logic [3:0]          i_nlbits,
  output logic                o_valid,
  output logic [SRC_W-1:0]    o_id,
  output logic [7:0]          o_level,
  output logic                o_shv
);

  // Heap-ordered complete binary tree: node k has children 2k+1 (left, lower IDs)
  // and 2k+2 (right, higher IDs). Leaves start at NP-1.
  localparam int NP    = 1 << SRC_W;
  localparam int NODES = 2 * NP - 1;

  logic             w_vld [NODES];
  logic [SRC_W-1:0] w_id  [NODES];
  logic [7:0]       w_ctl [NODES];
  logic             w_shv [NODES];

  for (genvar i = 0; i < NP; i++) begin : g_leaf
    localparam int L = NP - 1 + i;
    if (i < N_SOURCE) begin : g_src
      assign w_vld[L] = i_elig[i];
      assign w_ctl[L] = i_intctl[i];
      assign w_shv[L] = i_shv[i];
    end else begin : g_pad
      assign w_vld[L] = 1'b0;
      assign w_ctl[L] = 8'h00;
      assign w_shv[L] = 1'b0;
    end
    assign w_id[L] = SRC_W'(i);
  end

  for (genvar k = 0; k < NP - 1; k++) begin : g_node
    logic [15:0] w_key_l;
    logic [15:0] w_key_r;
    logic        w_pick_r;
    assign w_key_l  = {masked_level(w_ctl[2*k+1], i_nlbits), w_ctl[2*k+1]};
    assign w_key_r  = {masked_level(w_ctl[2*k+2], i_nlbits), w_ctl[2*k+2]};
    // Right subtree holds the higher IDs, so >= gives ties to the higher ID.
    assign w_pick_r = w_vld[2*k+2] & (~w_vld[2*k+1] | (w_key_r >= w_key_l));
    assign w_vld[k] = w_vld[2*k+1] | w_vld[2*k+2];
    assign w_id[k]  = w_pick_r ? w_id[2*k+2]  : w_id[2*k+1];
    assign w_ctl[k] = w_pick_r ? w_ctl[2*k+2] : w_ctl[2*k+1];
    assign w_shv[k] = w_pick_r ? w_shv[2*k+2] : w_shv[2*k+1];
  end

  assign o_valid = w_vld[0];
  assign o_id    = w_id[0];
  assign o_level = masked_level(w_ctl[0], i_nlbits);
  assign o_shv   = w_shv[0];

endmodule

// File: rtl/clic_target_arbiter.sv
// CLIC per-hart interrupt selection and delivery.
// Picks the highest-priority eligible source above the hart threshold, registers it
// as a candidate, and delivers it to the core over valid/ready. A delivered request
// that goes stale (source gone, better source, threshold raised) is withdrawn via
// kill_req/kill_ack. Claiming an edge-triggered source pulses edge_clr_o for one cycle.
//   clk_i, rst_ni           : clock, async active-low reset
//   ip_i/ie_i/le_i/shv_i    : per-source pending, enable, edge-trigger, shv
//   intctl_i, nlbits_i      : per-source intctl, level-bit count
//   thresh_i                : hart level threshold
//   irq_valid_o/irq_ready_i : request handshake; irq_id_o/irq_level_o/irq_shv_o payload
//   irq_kill_req_o/irq_kill_ack_i : withdrawal handshake
//   edge_clr_o              : one-hot, one-cycle pending clear
module clic_target_arbiter
  import clic_arb_pkg::*;
#(
  parameter int N_SOURCE   = 32,
  parameter int INTCTLBITS = 8,
  parameter int SRC_W      = $clog2(N_SOURCE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SOURCE-1:0] ip_i,
  input  logic [N_SOURCE-1:0] ie_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] shv_i,
  input  logic [7:0]          intctl_i [N_SOURCE],
  input  logic [3:0]          nlbits_i,
  input  logic [7:0]          thresh_i,
  output logic                irq_valid_o,
  input  logic                irq_ready_i,
  output logic [SRC_W-1:0]    irq_id_o,
  output logic [7:0]          irq_level_o,
  output logic                irq_shv_o,
  output logic                irq_kill_req_o,
  input  logic                irq_kill_ack_i,
  output logic [N_SOURCE-1:0] edge_clr_o
);

  localparam logic [7:0]          CTL_ONES = 8'(8'hFF >> INTCTLBITS);
  localparam logic [N_SOURCE-1:0] ONE_HOT0 = N_SOURCE'(1);

  // ---------------------------------------------------------------------------
  // Candidate selection
  // ---------------------------------------------------------------------------
  logic [7:0]          w_ctl [N_SOURCE];
  logic [N_SOURCE-1:0] w_elig;
  logic                w_tree_valid;
  logic [SRC_W-1:0]    w_tree_id;
  logic [7:0]          w_tree_level;
  logic                w_tree_shv;
  cand_t               w_cand;
  cand_t               r_cand;
  logic [N_SOURCE-1:0] r_clr;

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_ctl
    assign w_ctl[i] = intctl_i[i] | CTL_ONES;
  end

  // A source being cleared this cycle still shows pending until the register file
  // sees the pulse; masking it keeps the claimed source out of the next candidate.
  assign w_elig = ip_i & ie_i & ~r_clr;

  clic_max_tree #(
    .N_SOURCE (N_SOURCE),
    .SRC_W    (SRC_W)
  ) u_max_tree (
    .i_elig   (w_elig),
    .i_shv    (shv_i),
    .i_intctl (w_ctl),
    .i_nlbits (nlbits_i),
    .o_valid  (w_tree_valid),
    .o_id     (w_tree_id),
    .o_level  (w_tree_level),
    .o_shv    (w_tree_shv)
  );

  always_comb begin
    w_cand       = '0;
    w_cand.valid = w_tree_valid & (w_tree_level > thresh_i);
    w_cand.id    = CAND_ID_W'(w_tree_id);
    w_cand.level = w_tree_level;
    w_cand.shv   = w_tree_shv;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cand <= '0;
    else         r_cand <= w_cand;
  end

  // ---------------------------------------------------------------------------
  // Delivery FSM
  // ---------------------------------------------------------------------------
  arb_state_e           r_state, w_state_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_kill,  w_kill_nxt;
  logic                 r_hold,  w_hold_nxt;
  logic [CAND_ID_W-1:0] r_id,    w_id_nxt;
  logic [7:0]           r_level, w_level_nxt;
  logic                 r_shv,   w_shv_nxt;
  logic [N_SOURCE-1:0]  w_clr_nxt;
  logic [N_SOURCE-1:0]  w_sel;
  logic                 w_held_elig;
  logic                 w_stale;

  // One-hot of the held ID; avoids indexing the source vectors with the wide ID.
  assign w_sel       = ONE_HOT0 << r_id;
  assign w_held_elig = |(w_sel & ip_i & ie_i);
  assign w_stale     = ~w_held_elig
                     | (r_cand.valid & (r_cand.level > r_level))
                     | (r_level <= thresh_i);

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_kill_nxt  = r_kill;
    w_id_nxt    = r_id;
    w_level_nxt = r_level;
    w_shv_nxt   = r_shv;
    w_hold_nxt  = 1'b0;
    w_clr_nxt   = '0;
    unique case (r_state)
      IDLE: begin
        // r_hold marks the first IDLE cycle after a handshake; its candidate was
        // sampled before the claim and may be stale.
        if (r_cand.valid && !r_hold) begin
          w_valid_nxt = 1'b1;
          w_id_nxt    = r_cand.id;
          w_level_nxt = r_cand.level;
          w_shv_nxt   = r_cand.shv;
          w_state_nxt = REQ;
        end
      end
      REQ, KILL: begin
        // Acceptance wins over both kill detection and kill_ack.
        if (irq_ready_i) begin
          w_valid_nxt = 1'b0;
          w_kill_nxt  = 1'b0;
          w_clr_nxt   = w_sel & le_i;
          w_hold_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_state == KILL) begin
          if (irq_kill_ack_i) begin
            w_valid_nxt = 1'b0;
            w_kill_nxt  = 1'b0;
            w_hold_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (w_stale) begin
          w_kill_nxt  = 1'b1;
          w_state_nxt = KILL;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_kill_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_kill  <= 1'b0;
      r_hold  <= 1'b0;
      r_id    <= '0;
      r_level <= '0;
      r_shv   <= 1'b0;
      r_clr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_kill  <= w_kill_nxt;
      r_hold  <= w_hold_nxt;
      r_id    <= w_id_nxt;
      r_level <= w_level_nxt;
      r_shv   <= w_shv_nxt;
      r_clr   <= w_clr_nxt;
    end
  end

  assign irq_valid_o    = r_valid;
  assign irq_kill_req_o = r_kill;
  assign irq_id_o       = r_id[SRC_W-1:0];
  assign irq_level_o    = r_level;
  assign irq_shv_o      = r_shv;
  assign edge_clr_o     = r_clr;

endmodule

// File: tb/tb_clic_target_arbiter.sv
module tb_clic_target_arbiter;

  localparam int EV_VRISE = 0;
  localparam int EV_VFALL = 1;
  localparam int EV_KRISE = 2;
  localparam int EV_KFALL = 3;
  localparam int EV_CLR   = 4;

  typedef struct {
    int          kind;
    int          cyc;
    int          id;
    int          lvl;
    int          shv;
    logic [31:0] clr;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] ip, ie, le, shv;
  logic [7:0]  intctl [32];
  logic [3:0]  nlb;
  logic [7:0]  thr;
  logic        rdy, ack;
  logic        irq_valid_o, irq_shv_o, irq_kill_req_o;
  logic [4:0]  irq_id_o;
  logic [7:0]  irq_level_o;
  logic [31:0] edge_clr_o;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n;
  ev_t q[$];

  clic_target_arbiter #(.N_SOURCE(32), .INTCTLBITS(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ip_i           (ip),
    .ie_i           (ie),
    .le_i           (le),
    .shv_i          (shv),
    .intctl_i       (intctl),
    .nlbits_i       (nlb),
    .thresh_i       (thr),
    .irq_valid_o    (irq_valid_o),
    .irq_ready_i    (rdy),
    .irq_id_o       (irq_id_o),
    .irq_level_o    (irq_level_o),
    .irq_shv_o      (irq_shv_o),
    .irq_kill_req_o (irq_kill_req_o),
    .irq_kill_ack_i (ack),
    .edge_clr_o     (edge_clr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_VRISE: return "valid_rise";
      EV_VFALL: return "valid_fall";
      EV_KRISE: return "kill_rise";
      EV_KFALL: return "kill_fall";
      default:  return "edge_clr";
    endcase
  endfunction

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input int id, input int lvl,
                      input int sv, input logic [31:0] clr);
    ev_t e;
    e.kind = kind; e.cyc = c; e.id = id; e.lvl = lvl; e.shv = sv; e.clr = clr;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drained(input string nm);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain %s: %0d expected events never seen (next %s @%0d), want 0",
               nm, q.size(), kname(q[0].kind), q[0].cyc);
      q.delete();
    end
  endtask

  // Monitor: every output transition is an event that must match the queue head.
  task automatic observe(input int kind);
    ev_t e;
    logic bad;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL event unexpected: got %s @%0d id=%0d lvl=%h clr=%h, want none",
               kname(kind), cyc, irq_id_o, irq_level_o, edge_clr_o);
      return;
    end
    e = q.pop_front();
    bad = (e.kind != kind) || (e.cyc != cyc);
    if (kind == EV_VRISE)
      bad = bad || (int'(irq_id_o) != e.id) || (int'(irq_level_o) != e.lvl)
                || (int'(irq_shv_o) != e.shv);
    if (kind == EV_CLR) bad = bad || (edge_clr_o !== e.clr);
    if (bad) begin
      n_bad++;
      $display("FAIL event %s: got %s @%0d id=%0d lvl=%h shv=%0d clr=%h, want %s @%0d id=%0d lvl=%h shv=%0d clr=%h",
               kname(e.kind), kname(kind), cyc, irq_id_o, irq_level_o, irq_shv_o, edge_clr_o,
               kname(e.kind), e.cyc, e.id, e.lvl[7:0], e.shv, e.clr);
    end
  endtask

  initial begin
    logic pv, pk;
    pv = 1'b0; pk = 1'b0;
    forever begin
      @(negedge clk);
      if (irq_valid_o && !pv)    observe(EV_VRISE);
      if (!irq_valid_o && pv)    observe(EV_VFALL);
      if (irq_kill_req_o && !pk) observe(EV_KRISE);
      if (!irq_kill_req_o && pk) observe(EV_KFALL);
      if (edge_clr_o != '0)      observe(EV_CLR);
      pv = irq_valid_o;
      pk = irq_kill_req_o;
    end
  end

  initial begin
    rst_ni = 1'b0;
    ip = '0; ie = '0; le = '0; shv = '0;
    for (int i = 0; i < 32; i++) intctl[i] = 8'h00;
    nlb = 4'd8; thr = 8'h00; rdy = 1'b0; ack = 1'b0;
    tick(3);
    chk("reset valid", 32'(irq_valid_o), 32'd0);
    chk("reset kill",  32'(irq_kill_req_o), 32'd0);
    chk("reset id",    32'(irq_id_o), 32'd0);
    chk("reset level", 32'(irq_level_o), 32'd0);
    chk("reset shv",   32'(irq_shv_o), 32'd0);
    chk("reset clr",   edge_clr_o, 32'd0);
    rst_ni = 1'b1;
    tick(2);

    // Single edge-triggered source 5, claimed
    n = cyc;
    intctl[5] = 8'h80; ie[5] = 1; le[5] = 1; shv[5] = 1; ip[5] = 1;
    push(EV_VRISE, n+2, 5, 8'h80, 1, 0);
    tick(2); rdy = 1;
    push(EV_VFALL, n+3, 0, 0, 0, 0);
    push(EV_CLR,   n+3, 0, 0, 0, 32'h0000_0020);
    tick(1); rdy = 0; ip[5] = 0; ie[5] = 0; le[5] = 0; shv[5] = 0;
    tick(4); drained("single");

    // Masked levels tie at 7F; intctl decides (7 beats 3), then 3 follows
    nlb = 4'd2;
    n = cyc;
    intctl[3] = 8'h40; intctl[7] = 8'h5F; ie[3] = 1; ie[7] = 1; ip[3] = 1; ip[7] = 1;
    push(EV_VRISE, n+2, 7, 8'h7F, 0, 0);
    tick(2); rdy = 1;
    push(EV_VFALL, n+3, 0, 0, 0, 0);
    tick(1); rdy = 0; ip[7] = 0;
    push(EV_VRISE, n+5, 3, 8'h7F, 0, 0);
    tick(2); rdy = 1;
    push(EV_VFALL, n+6, 0, 0, 0, 0);
    tick(1); rdy = 0; ip[3] = 0;
    tick(3); drained("tie key");

    // Equal intctl: higher ID wins
    n = cyc;
    intctl[7] = 8'h40; ip[3] = 1; ip[7] = 1;
    push(EV_VRISE, n+2, 7, 8'h7F, 0, 0);
    tick(2); rdy = 1;
    push(EV_VFALL, n+3, 0, 0, 0, 0);
    tick(1); rdy = 0; ip[3] = 0; ip[7] = 0; ie[3] = 0; ie[7] = 0;
    tick(4); drained("tie id");

    // Threshold: level 3F vs thresh 3F blocked; 3E passes; raise back -> kill
    intctl[10] = 8'h00; thr = 8'h3F; ie[10] = 1; ip[10] = 1;
    tick(5); drained("thresh block");
    n = cyc;
    thr = 8'h3E;
    push(EV_VRISE, n+2, 10, 8'h3F, 0, 0);
    tick(2); thr = 8'h3F;
    push(EV_KRISE, n+3, 0, 0, 0, 0);
    tick(1); ack = 1;
    push(EV_VFALL, n+4, 0, 0, 0, 0);
    push(EV_KFALL, n+4, 0, 0, 0, 0);
    tick(1); ack = 0; ip[10] = 0; ie[10] = 0; thr = 8'h00;
    tick(4); drained("thresh");

    // Preemption: 2 @20 held, 9 @F0 arrives -> kill, ack, then 9, then 2
    nlb = 4'd8;
    n = cyc;
    intctl[2] = 8'h20; ie[2] = 1; ip[2] = 1;
    push(EV_VRISE, n+2, 2, 8'h20, 0, 0);
    tick(2); intctl[9] = 8'hF0; ie[9] = 1; ip[9] = 1;
    push(EV_KRISE, n+4, 0, 0, 0, 0);
    tick(2); ack = 1;
    push(EV_VFALL, n+5, 0, 0, 0, 0);
    push(EV_KFALL, n+5, 0, 0, 0, 0);
    tick(1); ack = 0;
    push(EV_VRISE, n+7, 9, 8'hF0, 0, 0);
    tick(2); rdy = 1;
    push(EV_VFALL, n+8, 0, 0, 0, 0);
    tick(1); rdy = 0; ip[9] = 0; ie[9] = 0;
    push(EV_VRISE, n+10, 2, 8'h20, 0, 0);
    tick(2); rdy = 1;
    push(EV_VFALL, n+11, 0, 0, 0, 0);
    tick(1); rdy = 0; ip[2] = 0; ie[2] = 0;
    tick(4); drained("preempt");

    // Race in KILL: ready and ack together count as accept, clear fires for 12
    n = cyc;
    intctl[12] = 8'h60; ie[12] = 1; ip[12] = 1; le[12] = 1; shv[12] = 1;
    push(EV_VRISE, n+2, 12, 8'h60, 1, 0);
    tick(2); intctl[20] = 8'h90; ie[20] = 1; ip[20] = 1;
    push(EV_KRISE, n+4, 0, 0, 0, 0);
    tick(2); rdy = 1; ack = 1;
    push(EV_VFALL, n+5, 0, 0, 0, 0);
    push(EV_KFALL, n+5, 0, 0, 0, 0);
    push(EV_CLR,   n+5, 0, 0, 0, 32'h0000_1000);
    tick(1); rdy = 0; ack = 0; ip[12] = 0; ie[12] = 0; le[12] = 0; shv[12] = 0;
    push(EV_VRISE, n+7, 20, 8'h90, 0, 0);
    tick(2); rdy = 1;
    push(EV_VFALL, n+8, 0, 0, 0, 0);
    tick(1); rdy = 0; ip[20] = 0; ie[20] = 0;
    tick(4); drained("race");

    // Reset while in REQ: outputs drop at once, request returns 2 cycles after release
    n = cyc;
    intctl[6] = 8'hA0; ie[6] = 1; ip[6] = 1;
    push(EV_VRISE, n+2, 6, 8'hA0, 0, 0);
    tick(3);
    push(EV_VFALL, n+3, 0, 0, 0, 0);
    rst_ni = 1'b0;
    #1;
    chk("midrst valid", 32'(irq_valid_o), 32'd0);
    chk("midrst kill",  32'(irq_kill_req_o), 32'd0);
    chk("midrst id",    32'(irq_id_o), 32'd0);
    chk("midrst level", 32'(irq_level_o), 32'd0);
    chk("midrst shv",   32'(irq_shv_o), 32'd0);
    chk("midrst clr",   edge_clr_o, 32'd0);
    tick(1); rst_ni = 1'b1;
    push(EV_VRISE, n+6, 6, 8'hA0, 0, 0);
    tick(2); rdy = 1;
    push(EV_VFALL, n+7, 0, 0, 0, 0);
    tick(1); rdy = 0; ip[6] = 0; ie[6] = 0;
    tick(4); drained("reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clic_target_arbiter.md
# clic_target_arbiter

Per-hart interrupt selection and delivery controller for the CLIC. Consumes the per-source configuration and pending state decoded from the `clicint` register file (intctl, shv, ie, trigger-edge, pending), resolves the highest-level eligible source against the hart threshold, and delivers it to the core over a valid/ready handshake. It withdraws a stale request via kill_req/kill_ack and emits a one-cycle clear pulse for edge-triggered sources when they are claimed.

## Interface
- N_SOURCE, 32: number of interrupt sources (≥2).
- INTCTLBITS, 8: implemented intctl bits; unimplemented low bits read as 1.
- SRC_W, $clog2(N_SOURCE): width of the source ID.
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- ip_i  in  N_SOURCE  pending per source (hardware OR software).
- ie_i  in  N_SOURCE  enable per source.
- le_i  in  N_SOURCE  1 = edge-triggered (pending cleared on claim).
- shv_i  in  N_SOURCE  selective hardware vectoring per source.
- intctl_i  in  8 × N_SOURCE  unpacked array of intctl values.
- nlbits_i  in  4  number of level bits from mcliccfg (values >8 treated as 8).
- thresh_i  in  8  hart interrupt-level threshold (mintthresh).
- irq_valid_o  out  1  interrupt request to the core.
- irq_ready_i  in  1  core accepts the request.
- irq_id_o  out  SRC_W  winning source ID.
- irq_level_o  out  8  winning level.
- irq_shv_o  out  1  winning source's shv bit.
- irq_kill_req_o  out  1  request withdrawal of the outstanding interrupt.
- irq_kill_ack_i  in  1  core confirms the withdrawal.
- edge_clr_o  out  N_SOURCE  one-hot, one-cycle pending-clear pulse.

## Operation
- Eligible(i) = ip_i[i] & ie_i[i].
- level(i) = intctl_i[i] with bits [7−nlbits:0] forced to 1. For nlbits=0, level = 8'hFF.
- Priority key = {level, intctl_i[i]}. On an equal key the higher ID wins.
- The combinational max-tree result is registered into a candidate stage: cand_valid, cand_id, cand_level, cand_shv.
- cand_valid = any eligible source & winner level > thresh_i.
- FSM has three states: IDLE, REQ, KILL.
- IDLE: when cand_valid, latch cand_* into the output registers, set irq_valid_o, and go to REQ.
- REQ: irq_valid_o=1 and outputs are held stable.
  - irq_ready_i → accept. If le_i[id], pulse edge_clr_o[id]. Clear irq_valid_o and go to IDLE.
  - Else, if the latched source is no longer eligible, or cand_level > latched level, or latched level ≤ thresh_i → go to KILL.
  - ready takes precedence over the kill conditions in the same cycle.
- KILL: irq_valid_o stays 1 and irq_kill_req_o=1.
  - irq_ready_i → treated as accept, with the same clear behaviour as in REQ; go to IDLE.
  - Else irq_kill_ack_i → clear both outputs and go to IDLE.
  - If ready and ack are asserted together, ready wins.
- No new request is issued in the cycle the FSM returns to IDLE.
- Reset values: irq_valid_o=0, irq_kill_req_o=0, irq_id_o=0, irq_level_o=0, irq_shv_o=0, edge_clr_o=0, state=IDLE, cand_valid=0.

## Timing
- ip_i rises in cycle n → cand_valid at n+1 → irq_valid_o at n+2.
- Handshake completes on the edge where irq_valid_o & irq_ready_i. edge_clr_o is high for exactly the following cycle.
- The earliest re-request after an accept or kill is 2 cycles later. The candidate is sampled in IDLE, so a stale candidate is never delivered if edge_clr_o has cleared ip_i.
- Kill detection has 1 cycle latency from the candidate stage; irq_kill_req_o rises 2 cycles after the better source's ip_i.
- Reset mid-handshake: all outputs drop asynchronously and the FSM returns to IDLE.

## Structure
- Package clic_arb_pkg holds:
  - the state enum (IDLE, REQ, KILL);
  - the masked-level function, mask = 8'hFF >> nlbits;
  - the candidate struct {valid, id, level, shv}.
- Sub-module clic_max_tree: a parameterised combinational comparator tree over N_SOURCE. It returns the {valid, id, level, shv} of the maximum key, breaking ties toward the higher ID.

## Test plan
- Single source: src 5, intctl 8'h80, nlbits 8, thresh 0, ie/ip set → irq_valid_o at cycle +2, id 5, level 8'h80. Ready, le=1 → edge_clr_o = 1<<5 for one cycle, then valid drops.
- Tie and masking: src 3 and src 7 with intctl 8'h40 and 8'h5F, nlbits 2 → both levels 8'h7F. Key decides: src 7 wins. With equal intctl, the higher ID wins.
- Threshold: level 8'h3F with thresh 8'h3F → no request. Lower thresh to 8'h3E → request after 2 cycles.
- Preemption: src 2 in REQ at level 8'h20, then src 9 rises at level 8'hF0 → kill_req 2 cycles later. kill_ack → IDLE, then src 9 is requested.
- Race: in KILL, assert ready and kill_ack together → treated as accepted. The edge clear fires for the held ID, and no second request is made for it.
- Reset: assert rst_ni low while in REQ → all outputs 0 immediately. After release, the request reappears 2 cycles later if the source is still eligible.
